// File: rtl/pool_2x2_pkg.sv
// Shared pixel/channel definitions for the conv -> ReLU -> pool datapath.
// Holds the channel count and width, the packed pixel width and a signed
// int8 max helper used wherever channels are compared.
package pool_2x2_pkg;

  localparam int unsigned CH_N  = 4;
  localparam int unsigned CH_W  = 8;
  localparam int unsigned PIX_W = CH_N * CH_W;

  // Signed int8 max; ties return the (equal) first operand.
  function automatic logic [CH_W-1:0] max_s8(input logic [CH_W-1:0] a,
                                             input logic [CH_W-1:0] b);
    return ($signed(b) > $signed(a)) ? b : a;
  endfunction

endpackage

// File: rtl/max4_s8.sv
// Per-channel signed max of two packed 4 x int8 pixels.
// Ports:
//   a, b   : packed pixels, ch1 in the top byte, ch4 in the bottom byte
//   max_c  : combinational per-channel signed max of a and b
module max4_s8
  import pool_2x2_pkg::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] max_c
);

  // Each byte lane is compared independently as a signed value.
  always_comb begin
    max_c = '0;
    for (int i = 0; i < int'(CH_N); i++) begin
      max_c[i*CH_W +: CH_W] = max_s8(a[i*CH_W +: CH_W], b[i*CH_W +: CH_W]);
    end
  end

endmodule

// File: rtl/pool_2x2.sv
// 2x2 stride-2 max pooling over a raster-order stream of 4 x int8 pixels.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   data_i     : input pixel, ch1 = [31:24] .. ch4 = [7:0]
//   valid_i    : one pixel per asserted cycle, no backpressure
//   data_o     : pooled pixel, same packing; holds when valid_o is low
//   valid_o    : one-cycle qualifier for data_o
//   pool_done  : one-cycle pulse with the last pooled pixel of a frame
module pool_2x2
  import pool_2x2_pkg::*;
#(
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] data_i,
  input  logic             valid_i,
  output logic [PIX_W-1:0] data_o,
  output logic             valid_o,
  output logic             pool_done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned LB_D  = IMG_W / 2;
  localparam int unsigned LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PIX_W-1:0] hold;
  logic [PIX_W-1:0] line_buf [LB_D];

  logic             col_last_c;
  logic             row_last_c;
  logic             odd_col_c;
  logic             odd_row_c;
  logic [LB_AW-1:0] lb_idx_c;
  logic [PIX_W-1:0] lb_rd_c;
  logic [PIX_W-1:0] pair_max_c;
  logic [PIX_W-1:0] win_max_c;

  // Position decode for the pixel currently on data_i.
  always_comb begin
    col_last_c = (col == COL_W'(IMG_W - 1));
    row_last_c = (row == ROW_W'(IMG_H - 1));
    odd_col_c  = col[0];
    odd_row_c  = row[0];
    lb_idx_c   = LB_AW'(col >> 1);
    lb_rd_c    = line_buf[lb_idx_c];
  end

  // Horizontal pair max: held even-column pixel vs current odd-column pixel.
  max4_s8 u_pair_max (
    .a     (hold),
    .b     (data_i),
    .max_c (pair_max_c)
  );

  // Vertical max: current pair vs the pair stored from the even row above.
  max4_s8 u_row_max (
    .a     (pair_max_c),
    .b     (lb_rd_c),
    .max_c (win_max_c)
  );

  // Position counters, pair-hold register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      pool_done <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      pool_done <= 1'b0;
      if (valid_i) begin
        if (!odd_col_c) begin
          hold <= data_i;
        end
        if (odd_col_c && odd_row_c) begin
          data_o    <= win_max_c;
          valid_o   <= 1'b1;
          pool_done <= row_last_c && col_last_c;
        end
        if (col_last_c) begin
          col <= '0;
          row <= row_last_c ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // Line buffer needs no reset: every entry is written on the even row
  // before the odd row reads it. Reads (odd rows) and writes (even rows)
  // never target the same cycle's row, so back-to-back frames are safe.
  always_ff @(posedge clk) begin
    if (!rst && valid_i && odd_col_c && !odd_row_c) begin
      line_buf[lb_idx_c] <= pair_max_c;
    end
  end

endmodule

// File: tb/tb_pool_2x2.sv
// Scoreboard bench for pool_2x2: a 4x2 instance for directed cases and a
// default 32x32 instance for random frames against a window-max model.
module tb_pool_2x2;

  localparam int SW = 4;
  localparam int SH = 2;
  localparam int BW = 32;
  localparam int BH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst, s_valid, s_vout, s_done;
  logic [31:0] s_data, s_dout;
  logic        b_rst, b_valid, b_vout, b_done;
  logic [31:0] b_data, b_dout;

  pool_2x2 #(.IMG_W(SW), .IMG_H(SH)) u_small (
    .clk(clk), .rst(s_rst), .data_i(s_data), .valid_i(s_valid),
    .data_o(s_dout), .valid_o(s_vout), .pool_done(s_done)
  );

  pool_2x2 #(.IMG_W(BW), .IMG_H(BH)) u_big (
    .clk(clk), .rst(b_rst), .data_i(b_data), .valid_i(b_valid),
    .data_o(b_dout), .valid_o(b_vout), .pool_done(b_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] d;
    logic        done;
  } exp_t;

  exp_t s_q[$];
  exp_t b_q[$];
  int   s_cq[$];
  int   b_cq[$];

  logic [31:0] s_frame [SW*SH];
  logic [31:0] b_frame [BW*BH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Max of a 2x2 window, computed per channel as signed integers.
  function automatic logic [31:0] win_max(input logic [31:0] p0, input logic [31:0] p1,
                                          input logic [31:0] p2, input logic [31:0] p3);
    logic [31:0] px [4];
    logic [31:0] r;
    logic [7:0]  b;
    int          m, v;
    px[0] = p0; px[1] = p1; px[2] = p2; px[3] = p3;
    r = '0;
    for (int ch = 0; ch < 4; ch++) begin
      m = -1000;
      for (int k = 0; k < 4; k++) begin
        b = px[k][ch*8 +: 8];
        v = int'($signed(b));
        if (v > m) m = v;
      end
      r[ch*8 +: 8] = 8'(m);
    end
    return r;
  endfunction

  task automatic push_small();
    exp_t e;
    int   idx;
    for (int pr = 0; pr < SH/2; pr++)
      for (int pc = 0; pc < SW/2; pc++) begin
        idx    = 2*pr*SW + 2*pc;
        e.d    = win_max(s_frame[idx], s_frame[idx+1], s_frame[idx+SW], s_frame[idx+SW+1]);
        e.done = (pr == SH/2-1) && (pc == SW/2-1);
        s_q.push_back(e);
      end
  endtask

  task automatic push_big();
    exp_t e;
    int   idx;
    for (int pr = 0; pr < BH/2; pr++)
      for (int pc = 0; pc < BW/2; pc++) begin
        idx    = 2*pr*BW + 2*pc;
        e.d    = win_max(b_frame[idx], b_frame[idx+1], b_frame[idx+BW], b_frame[idx+BW+1]);
        e.done = (pr == BH/2-1) && (pc == BW/2-1);
        b_q.push_back(e);
      end
  endtask

  // Drive n pixels; gap < 0 means a random 0..2 idle cycles after each pixel.
  // The output for a window is due the cycle after its bottom-right pixel.
  task automatic drive_small(input int n, input int gap);
    int g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = s_frame[i];
      if (((i / SW) % 2 == 1) && ((i % SW) % 2 == 1)) s_cq.push_back(cyc + 1);
      g = (gap < 0) ? int'($urandom_range(2)) : gap;
      repeat (g) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = $urandom;
      end
    end
  endtask

  task automatic drive_big(input int n, input int gap);
    int g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b_valid = 1'b1;
      b_data  = b_frame[i];
      if (((i / BW) % 2 == 1) && ((i % BW) % 2 == 1)) b_cq.push_back(cyc + 1);
      g = (gap < 0) ? int'($urandom_range(2)) : gap;
      repeat (g) begin
        @(negedge clk);
        b_valid = 1'b0;
        b_data  = $urandom;
      end
    end
  endtask

  task automatic small_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic fill_small_index(input logic [7:0] base);
    logic [7:0] v;
    for (int i = 0; i < SW*SH; i++) begin
      v = base + 8'(i);
      s_frame[i] = {4{v}};
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents an output.
  logic [31:0] s_last = '0;
  logic [31:0] b_last = '0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (s_rst) begin
      s_last = '0;
    end else begin
      if (s_done && !s_vout) check("s_done_without_valid", 32'(s_done), 32'(0));
      if (s_vout) begin
        if (s_q.size() == 0) begin
          check("s_unexpected_output", s_dout, 32'hxxxx_xxxx);
        end else begin
          e = s_q.pop_front();
          check("s_data", s_dout, e.d);
          check("s_pool_done", 32'(s_done), 32'(e.done));
          if (s_cq.size() != 0) check("s_latency_cycle", 32'(cyc), 32'(s_cq.pop_front()));
        end
        s_last = s_dout;
      end else begin
        check("s_data_hold", s_dout, s_last);
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (b_rst) begin
      b_last = '0;
    end else begin
      if (b_done && !b_vout) check("b_done_without_valid", 32'(b_done), 32'(0));
      if (b_vout) begin
        if (b_q.size() == 0) begin
          check("b_unexpected_output", b_dout, 32'hxxxx_xxxx);
        end else begin
          e = b_q.pop_front();
          check("b_data", b_dout, e.d);
          check("b_pool_done", 32'(b_done), 32'(e.done));
          if (b_cq.size() != 0) check("b_latency_cycle", 32'(cyc), 32'(b_cq.pop_front()));
        end
        b_last = b_dout;
      end else if (!b_done) begin
        check("b_data_hold", b_dout, b_last);
      end
    end
  end

  initial begin
    int wait_cnt;
    s_rst = 1'b1; s_valid = 1'b0; s_data = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_data = '0;
    repeat (3) @(negedge clk);
    check("s_reset_valid_o", 32'(s_vout), 32'(0));
    check("s_reset_pool_done", 32'(s_done), 32'(0));
    check("s_reset_data_o", s_dout, 32'h0);
    check("b_reset_valid_o", 32'(b_vout), 32'(0));
    check("b_reset_data_o", b_dout, 32'h0);
    s_rst = 1'b0;
    b_rst = 1'b0;

    // Index ramp: expect 0x05050505 then 0x07070707 with pool_done.
    fill_small_index(8'h00);
    push_small();
    drive_small(SW*SH, 0);
    small_idle(3);

    // Mixed signs: ch1 = -128 everywhere in window 0, ch4 = {-1,-5,-128,-2}.
    for (int i = 0; i < SW*SH; i++) s_frame[i] = $urandom;
    s_frame[0][31:24] = 8'h80; s_frame[1][31:24] = 8'h80;
    s_frame[4][31:24] = 8'h80; s_frame[5][31:24] = 8'h80;
    s_frame[0][7:0] = 8'hFF; s_frame[1][7:0] = 8'hFB;
    s_frame[4][7:0] = 8'h80; s_frame[5][7:0] = 8'hFE;
    push_small();
    drive_small(SW*SH, 0);
    small_idle(3);

    // Ramp with 3 idle cycles between pixels.
    fill_small_index(8'h00);
    push_small();
    drive_small(SW*SH, 3);
    small_idle(2);

    // Two back-to-back frames, second offset by 0x10 per byte.
    fill_small_index(8'h00);
    push_small();
    drive_small(SW*SH, 0);
    fill_small_index(8'h10);
    push_small();
    drive_small(SW*SH, 0);
    small_idle(3);

    // Abort mid-frame with valid_i held high during reset, then a clean frame.
    fill_small_index(8'h40);
    drive_small(5, 0);
    @(negedge clk);
    s_rst = 1'b1; s_valid = 1'b1; s_data = $urandom;
    @(negedge clk);
    s_data = $urandom;
    @(negedge clk);
    s_rst = 1'b0; s_valid = 1'b0;
    small_idle(2);
    fill_small_index(8'h20);
    push_small();
    drive_small(SW*SH, 0);
    small_idle(3);

    // Random small frames with random gaps, including ties and extremes.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < SW*SH; i++) s_frame[i] = (f == 0) ? 32'h7F80_0000 : $urandom;
      push_small();
      drive_small(SW*SH, -1);
    end
    small_idle(3);

    // Default geometry: three random frames, first back-to-back, rest gapped.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < BW*BH; i++) b_frame[i] = $urandom;
      push_big();
      drive_big(BW*BH, (f == 0) ? 0 : -1);
    end
    @(negedge clk);
    b_valid = 1'b0;

    wait_cnt = 0;
    while ((s_q.size() != 0 || b_q.size() != 0) && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("s_all_outputs_seen", 32'(s_q.size()), 32'(0));
    check("b_all_outputs_seen", 32'(b_q.size()), 32'(0));
    check("s_latency_queue_empty", 32'(s_cq.size()), 32'(0));
    check("b_latency_queue_empty", 32'(b_cq.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
